page_table_walker: RTL and testbench
====================================

# page_table_walker

Hardware page-table walker sitting behind the TLB: it accepts a TLB miss, walks a two-level page table in memory over a req/ack read port, and answers with a one-cycle MMU update carrying the translated physical page. If the walk finds an invalid or malformed entry, it raises a one-cycle fault instead. It is the responder side of the TLB's `mmu_update_request` / `mmu_paddr` interface.

## Interface
- `VA_WIDTH`, 32, virtual/physical address width (fixed; other values unsupported)
- `PAGE_BITS`, 12, page offset width (fixed)

- `clk` in 1: clock
- `reset` in 1: reset, synchronous, active-high
- `miss_valid` in 1: TLB miss, walk requested
- `miss_vaddr` in 32: missing virtual address
- `miss_ready` out 1: walker idle, miss accepted when `miss_valid && miss_ready`
- `root_ppn` in 20: physical page number of the level-1 table, sampled at accept
- `mem_req` out 1: memory read request
- `mem_addr` out 32: word-aligned read address
- `mem_ack` in 1: read data valid this cycle
- `mem_rdata` in 32: page-table entry (PTE)
- `mmu_update_request` out 1: one-cycle pulse, TLB fill
- `mmu_paddr` out 32: `{ppage, 12'h000}`
- `mmu_vaddr` out 32: vaddr of the fill (TLB tag/index source)
- `fault` out 1: one-cycle pulse, translation fault
- `fault_vaddr` out 32: faulting vaddr

## Operation
- PTE format: [0] valid, [1] leaf, [31:12] ppn; other bits are ignored.
- L1 address = `{root_ppn, vaddr[31:22], 2'b00}`. L2 address = `{pte1.ppn, vaddr[21:12], 2'b00}`.
- FSM states and transitions:
  - IDLE: `miss_ready` = 1. On accept, latch vaddr and root_ppn, then go to L1_REQ.
  - L1_REQ: `mem_req` = 1, `mem_addr` = L1 address. On `mem_ack`:
    - invalid → FAULT
    - valid non-leaf → L2_REQ
    - valid leaf (superpage) with ppn[9:0] == 0 → UPDATE, ppage = `{ppn[19:10], vaddr[21:12]}`
    - valid leaf with ppn[9:0] != 0 → FAULT
  - L2_REQ: `mem_req` = 1, `mem_addr` = L2 address. On `mem_ack`:
    - valid leaf → UPDATE, ppage = ppn
    - invalid or non-leaf → FAULT
  - UPDATE: `mmu_update_request` = 1 for one cycle → IDLE.
  - FAULT: `fault` = 1 for one cycle → IDLE.
- `mem_req` and `mem_addr` are held stable until `mem_ack`. `mem_rdata` is sampled only in the ack cycle.
- `mem_ack` outside L1_REQ/L2_REQ is ignored.
- `miss_valid` while busy is not accepted; the requester holds it.
- `mmu_vaddr` and `fault_vaddr` equal the latched vaddr. They are valid during their pulse and hold until the next accept.
- `mmu_paddr` low 12 bits are always 0.

## Timing
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- Reset values: `miss_ready` = 1, `mem_req` = 0, `mem_addr` = 0, `mmu_update_request` = 0, `mmu_paddr` = 0, `mmu_vaddr` = 0, `fault` = 0, `fault_vaddr` = 0. State = IDLE.
- Latency, with accept at edge 0 and zero-wait acks:
  - `mem_req` is asserted in cycle 1.
  - L2 request in cycle 2.
  - Update pulse in cycle 3 for a two-level walk; cycle 2 for a superpage or L1 fault.
  - Each wait cycle on `mem_ack` adds one cycle.
- Next miss: `miss_ready` returns the cycle after the UPDATE/FAULT pulse, so back-to-back walks are separated by one idle cycle.
- Reset mid-walk: IDLE and all outputs at reset values the next cycle. No update or fault is emitted; a late `mem_ack` is ignored.

## Structure
- Package `mmu_pkg` holds:
  - `pte_t` packed struct (ppn, reserved, leaf, valid)
  - walker state enum
  - constants for VPN1/VPN2 bit positions
  - `pte_check` function returning next action (descend/leaf/fault), shared with future walker variants
- Single module; no sub-module is needed.

## Test plan
- Two-level hit. `root_ppn`=0x00010, vaddr 0x0040_3ABC:
  - L1 read at 0x0001_0004; return 0x0002_0001.
  - L2 read at 0x0002_000C; return 0x1234_5003.
  - Expect `mmu_update_request` pulse in cycle 3, `mmu_paddr` 0x1234_5000, `mmu_vaddr` 0x0040_3ABC.
- Superpage. Same vaddr; L1 returns 0x8000_0003 → update in cycle 2 with `mmu_paddr` 0x8000_3000 and no L2 read.
- Faults (one `fault` pulse each, `fault_vaddr` 0x0040_3ABC, no update):
  - L1 returns 0x0000_0000
  - L1 returns misaligned superpage 0x8000_1003
  - L2 returns non-leaf 0x1234_5001
- Wait states. Delay `mem_ack` 5 cycles on each level:
  - `mem_addr` stays stable throughout.
  - Update arrives in cycle 13.
  - A second `miss_valid` during the walk is not accepted until `miss_ready` returns.
- Reset during L2_REQ:
  - Next cycle `mem_req` = 0 and `miss_ready` = 1.
  - A subsequent stray `mem_ack` causes no update or fault.
  - A fresh walk then completes correctly.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared page-table definitions for the two-level (Sv32-like) walker family.
package mmu_pkg;

    // Virtual-address field positions for the two table levels.
    localparam int unsigned Vpn1Msb = 31;
    localparam int unsigned Vpn1Lsb = 22;
    localparam int unsigned Vpn2Msb = 21;
    localparam int unsigned Vpn2Lsb = 12;

    // Superpage alignment: the low PPN bits a level-1 leaf must leave clear.
    localparam int unsigned SuperAlignBits = Vpn1Lsb - Vpn2Lsb;

    typedef struct packed {
        logic [19:0] ppn;
        logic [9:0]  reserved;
        logic        leaf;
        logic        valid;
    } pte_t;

    typedef enum logic [2:0] {
        StIdle,
        StL1Req,
        StL2Req,
        StUpdate,
        StFault
    } walk_state_e;

    typedef enum logic [1:0] {
        ActDescend,
        ActLeaf,
        ActFault
    } pte_action_e;

    // Decide what a fetched PTE means at a given level; the last level may not descend.
    function automatic pte_action_e pte_check(input pte_t pte, input logic last_level);
        pte_action_e act;
        if (!pte.valid) begin
            act = ActFault;
        end else if (last_level) begin
            act = pte.leaf ? ActLeaf : ActFault;
        end else if (!pte.leaf) begin
            act = ActDescend;
        end else if (pte.ppn[SuperAlignBits-1:0] == '0) begin
            act = ActLeaf;
        end else begin
            act = ActFault;
        end
        return act;
    endfunction

endpackage

// File: rtl/page_table_walker.sv
// Two-level hardware page-table walker answering TLB misses with a fill or a fault pulse.
module page_table_walker
    import mmu_pkg::*;
#(
    parameter int unsigned VA_WIDTH  = 32,
    parameter int unsigned PAGE_BITS = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          miss_valid,
    input  logic [VA_WIDTH-1:0]           miss_vaddr,
    output logic                          miss_ready,
    input  logic [VA_WIDTH-PAGE_BITS-1:0] root_ppn,
    output logic                          mem_req,
    output logic [VA_WIDTH-1:0]           mem_addr,
    input  logic                          mem_ack,
    input  logic [31:0]                   mem_rdata,
    output logic                          mmu_update_request,
    output logic [VA_WIDTH-1:0]           mmu_paddr,
    output logic [VA_WIDTH-1:0]           mmu_vaddr,
    output logic                          fault,
    output logic [VA_WIDTH-1:0]           fault_vaddr
);

    walk_state_e                   state_q;
    logic                          miss_ready_q;
    logic                          mem_req_q;
    logic [VA_WIDTH-1:0]           mem_addr_q;
    logic                          update_q;
    logic                          fault_q;
    logic [VA_WIDTH-PAGE_BITS-1:0] ppage_q;
    logic [VA_WIDTH-1:0]           vaddr_q;

    // Walk FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            miss_ready_q <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            update_q     <= 1'b0;
            fault_q      <= 1'b0;
            ppage_q      <= '0;
            vaddr_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (miss_valid) begin
                        // root_ppn is only needed to form the L1 address, so fold it in now.
                        vaddr_q      <= miss_vaddr;
                        mem_addr_q   <= {root_ppn, miss_vaddr[Vpn1Msb:Vpn1Lsb], 2'b00};
                        mem_req_q    <= 1'b1;
                        miss_ready_q <= 1'b0;
                        state_q      <= StL1Req;
                    end
                end
                StL1Req: begin
                    if (mem_ack) begin
                        unique case (pte_check(pte_t'(mem_rdata), 1'b0))
                            ActDescend: begin
                                mem_addr_q <= {mem_rdata[31:12], vaddr_q[Vpn2Msb:Vpn2Lsb], 2'b00};
                                state_q    <= StL2Req;
                            end
                            ActLeaf: begin
                                // Superpage: VPN2 passes straight through into the page number.
                                mem_req_q <= 1'b0;
                                ppage_q   <= {mem_rdata[31:22], vaddr_q[Vpn2Msb:Vpn2Lsb]};
                                update_q  <= 1'b1;
                                state_q   <= StUpdate;
                            end
                            ActFault: begin
                                mem_req_q <= 1'b0;
                                fault_q   <= 1'b1;
                                state_q   <= StFault;
                            end
                        endcase
                    end
                end
                StL2Req: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (pte_check(pte_t'(mem_rdata), 1'b1) == ActLeaf) begin
                            ppage_q  <= mem_rdata[31:12];
                            update_q <= 1'b1;
                            state_q  <= StUpdate;
                        end else begin
                            fault_q <= 1'b1;
                            state_q <= StFault;
                        end
                    end
                end
                StUpdate, StFault: begin
                    update_q     <= 1'b0;
                    fault_q      <= 1'b0;
                    miss_ready_q <= 1'b1;
                    state_q      <= StIdle;
                end
                default: begin
                    state_q      <= StIdle;
                    miss_ready_q <= 1'b1;
                    mem_req_q    <= 1'b0;
                    update_q     <= 1'b0;
                    fault_q      <= 1'b0;
                end
            endcase
        end
    end

    assign miss_ready         = miss_ready_q;
    assign mem_req            = mem_req_q;
    assign mem_addr           = mem_addr_q;
    assign mmu_update_request = update_q;
    assign mmu_paddr          = {ppage_q, {PAGE_BITS{1'b0}}};
    assign mmu_vaddr          = vaddr_q;
    assign fault              = fault_q;
    assign fault_vaddr        = vaddr_q;

endmodule

// File: tb/tb_page_table_walker.sv
// Self-checking bench for page_table_walker: directed walks plus randomized walks vs a model.
module tb_page_table_walker;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss_valid;
    logic [31:0] miss_vaddr;
    logic        miss_ready;
    logic [19:0] root_ppn;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mmu_update_request;
    logic [31:0] mmu_paddr;
    logic [31:0] mmu_vaddr;
    logic        fault;
    logic [31:0] fault_vaddr;

    int unsigned checks = 0;
    int unsigned errors = 0;

    page_table_walker dut (
        .clk                (clk),
        .reset              (reset),
        .miss_valid         (miss_valid),
        .miss_vaddr         (miss_vaddr),
        .miss_ready         (miss_ready),
        .root_ppn           (root_ppn),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata),
        .mmu_update_request (mmu_update_request),
        .mmu_paddr          (mmu_paddr),
        .mmu_vaddr          (mmu_vaddr),
        .fault              (fault),
        .fault_vaddr        (fault_vaddr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference translation computed with plain arithmetic from the PTE rules.
    function automatic void model(input int unsigned root, input int unsigned va,
                                  input int unsigned l1, input int unsigned l2,
                                  output bit two_level, output bit is_fault,
                                  output int unsigned pa, output int unsigned a1,
                                  output int unsigned a2);
        a1        = root * 4096 + (va / 4194304) * 4;
        a2        = (l1 / 4096) * 4096 + ((va / 4096) % 1024) * 4;
        two_level = 0;
        is_fault  = 0;
        pa        = 0;
        if (l1 % 2 == 0) begin
            is_fault = 1;
        end else if ((l1 / 2) % 2 == 1) begin
            if ((l1 / 4096) % 1024 != 0) is_fault = 1;
            else pa = (l1 / 4194304) * 4194304 + ((va / 4096) % 1024) * 4096;
        end else begin
            two_level = 1;
            if (l2 % 4 == 3) pa = (l2 / 4096) * 4096;
            else is_fault = 1;
        end
    endfunction

    // Issue one miss and serve its memory reads; optionally keep a second miss pending.
    task automatic walk(input logic [19:0] root, input logic [31:0] va, input logic [31:0] l1,
                        input logic [31:0] l2, input int w1, input int w2,
                        input bit hold, input logic [31:0] va2);
        bit          two_level;
        bit          is_fault;
        int unsigned pa;
        int unsigned a1;
        int unsigned a2;
        model(root, va, l1, l2, two_level, is_fault, pa, a1, a2);
        check("ready_before_miss", miss_ready, 1);
        miss_valid = 1'b1;
        miss_vaddr = va;
        root_ppn   = root;
        tick();
        if (hold) miss_vaddr = va2;
        else miss_valid = 1'b0;
        check("l1_req", mem_req, 1);
        check("l1_addr", mem_addr, a1);
        for (int i = 0; i < w1; i++) begin
            tick();
            check("l1_wait_req", mem_req, 1);
            check("l1_wait_addr", mem_addr, a1);
            check("busy_not_ready", miss_ready, 0);
        end
        check("no_early_pulse", {30'd0, mmu_update_request, fault}, 0);
        mem_ack   = 1'b1;
        mem_rdata = l1;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (two_level) begin
            check("l2_req", mem_req, 1);
            check("l2_addr", mem_addr, a2);
            for (int i = 0; i < w2; i++) begin
                tick();
                check("l2_wait_req", mem_req, 1);
                check("l2_wait_addr", mem_addr, a2);
                check("busy_not_ready", miss_ready, 0);
            end
            mem_ack   = 1'b1;
            mem_rdata = l2;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end
        check("pulse_update", mmu_update_request, is_fault ? 0 : 1);
        check("pulse_fault", fault, is_fault ? 1 : 0);
        check("pulse_no_req", mem_req, 0);
        if (is_fault) begin
            check("fault_vaddr", fault_vaddr, va);
        end else begin
            check("mmu_paddr", mmu_paddr, pa);
            check("mmu_vaddr", mmu_vaddr, va);
        end
        tick();
        check("post_pulse_clear", {30'd0, mmu_update_request, fault}, 0);
        check("post_pulse_ready", miss_ready, 1);
    endtask

    initial begin
        reset      = 1'b1;
        miss_valid = 1'b0;
        miss_vaddr = '0;
        root_ppn   = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        tick();
        tick();
        check("rst_miss_ready", miss_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_update", mmu_update_request, 0);
        check("rst_paddr", mmu_paddr, 0);
        check("rst_vaddr", mmu_vaddr, 0);
        check("rst_fault", fault, 0);
        check("rst_fault_vaddr", fault_vaddr, 0);
        reset = 1'b0;
        // Acks while idle must not do anything.
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5003;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_ignored", {29'd0, mem_req, mmu_update_request, fault}, 0);
        tick();

        // Directed walks.
        walk(20'h00010, 32'h0040_3ABC, 32'h0002_0001, 32'h1234_5003, 0, 0, 0, 0);
        tick();
        walk(20'h00010, 32'h0040_3ABC, 32'h8000_0003, 32'h0, 0, 0, 0, 0);
        tick();
        walk(20'h00010, 32'h0040_3ABC, 32'h0000_0000, 32'h0, 0, 0, 0, 0);
        tick();
        walk(20'h00010, 32'h0040_3ABC, 32'h8000_1003, 32'h0, 0, 0, 0, 0);
        tick();
        walk(20'h00010, 32'h0040_3ABC, 32'h0002_0001, 32'h1234_5001, 0, 0, 0, 0);
        tick();
        // Wait states with a second miss held pending; it is accepted right after.
        walk(20'h00010, 32'h0040_3ABC, 32'h0002_0001, 32'h1234_5003, 5, 5, 1, 32'hFFC0_1234);
        walk(20'h00ABC, 32'hFFC0_1234, 32'h0003_0001, 32'h0BAD_F003, 0, 0, 0, 0);
        tick();

        // Reset while the L2 read is outstanding.
        miss_valid = 1'b1;
        miss_vaddr = 32'h0040_3ABC;
        root_ppn   = 20'h00010;
        tick();
        miss_valid = 1'b0;
        mem_ack    = 1'b1;
        mem_rdata  = 32'h0002_0001;
        tick();
        mem_ack = 1'b0;
        check("pre_rst_l2_req", mem_req, 1);
        check("pre_rst_l2_addr", mem_addr, 32'h0002_000C);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_mem_req", mem_req, 0);
        check("midrst_ready", miss_ready, 1);
        check("midrst_vaddr", mmu_vaddr, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5003;
        tick();
        mem_ack = 1'b0;
        check("stray_ack_no_pulse", {30'd0, mmu_update_request, fault}, 0);
        check("stray_ack_no_req", mem_req, 0);
        tick();
        check("stray_ack_no_pulse2", {30'd0, mmu_update_request, fault}, 0);
        walk(20'h00010, 32'h0040_3ABC, 32'h0002_0001, 32'h1234_5003, 0, 0, 0, 0);
        tick();

        // Randomized walks over all PTE categories.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] va;
            logic [31:0] l1;
            logic [31:0] l2;
            logic [31:0] r;
            logic [19:0] root;
            int          k1;
            int          k2;
            va   = $urandom;
            r    = $urandom;
            root = r[19:0];
            r    = $urandom;
            k1   = $urandom_range(0, 5);
            if (k1 == 0) l1 = {r[31:1], 1'b0};
            else if (k1 == 1) l1 = {r[31:22], 10'd0, r[11:2], 2'b11};
            else if (k1 == 2) l1 = {r[31:22], r[21:13], 1'b1, r[11:2], 2'b11};
            else l1 = {r[31:2], 2'b01};
            r  = $urandom;
            k2 = $urandom_range(0, 3);
            if (k2 == 0) l2 = {r[31:1], 1'b0};
            else if (k2 == 1) l2 = {r[31:2], 2'b01};
            else l2 = {r[31:2], 2'b11};
            walk(root, va, l1, l2, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
